// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU fetch/data ports, the arbiter and the shared
// single-ported memory. The arbiter takes the slave view; the CPU plus
// memory environment takes the master view.
interface mem_arbiter_if;
    // Instruction-fetch port
    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_ack_o;
    // Data port
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_ack_o;
    // Pipeline control and ownership
    logic        stall_req_o;
    logic [1:0]  grant_o;
    // Memory side
    logic        bus_ce_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;

    modport slave (
        input  if_ce_i, if_addr_i,
        input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_wdata_i,
        input  bus_rdata_i,
        output if_data_o, if_ack_o,
        output mem_rdata_o, mem_ack_o,
        output stall_req_o, grant_o,
        output bus_ce_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o
    );

    modport master (
        output if_ce_i, if_addr_i,
        output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_wdata_i,
        output bus_rdata_i,
        input  if_data_o, if_ack_o,
        input  mem_rdata_o, mem_ack_o,
        input  stall_req_o, grant_o,
        input  bus_ce_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-ported memory between instruction
// fetch and the data stage. Each access holds the bus for WAIT_STATES+1
// cycles, followed by a single acknowledge cycle. Conflicts alternate
// between the ports, with the data port winning the first one.
module mem_arbiter #(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_ACK   = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES);

    logic [1:0]  state_r;
    logic [3:0]  cnt_r;
    logic        last_grant_r;   // 0 = IF won last, 1 = MEM won last
    logic [1:0]  grant_r;
    logic        bus_ce_r;
    logic        bus_we_r;
    logic [31:0] bus_addr_r;
    logic [3:0]  bus_sel_r;
    logic [31:0] bus_wdata_r;
    logic [31:0] if_data_r;
    logic [31:0] mem_rdata_r;
    logic        if_ack_r;
    logic        mem_ack_r;

    logic        req_any_s;
    logic        win_mem_s;

    // Pick the next owner: a lone requester wins, a conflict goes to the loser of the last round
    always_comb begin
        req_any_s = bus.if_ce_i | bus.mem_ce_i;
        if (bus.if_ce_i && bus.mem_ce_i) begin
            win_mem_s = ~last_grant_r;
        end else begin
            win_mem_s = bus.mem_ce_i;
        end
    end

    // Access sequencer: arbitrate, hold the bus for the wait states, then acknowledge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            last_grant_r <= 1'b0;
            grant_r      <= 2'b00;
            bus_ce_r     <= 1'b0;
            bus_we_r     <= 1'b0;
            bus_addr_r   <= 32'h0000_0000;
            bus_sel_r    <= 4'h0;
            bus_wdata_r  <= 32'h0000_0000;
            if_data_r    <= 32'h0000_0000;
            mem_rdata_r  <= 32'h0000_0000;
            if_ack_r     <= 1'b0;
            mem_ack_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if_ack_r  <= 1'b0;
                    mem_ack_r <= 1'b0;
                    if (req_any_s) begin
                        state_r      <= ST_BUSY;
                        cnt_r        <= CNT_INIT;
                        bus_ce_r     <= 1'b1;
                        last_grant_r <= win_mem_s;
                        if (win_mem_s) begin
                            grant_r     <= 2'b10;
                            bus_we_r    <= bus.mem_we_i;
                            bus_addr_r  <= bus.mem_addr_i;
                            bus_sel_r   <= bus.mem_sel_i;
                            bus_wdata_r <= bus.mem_wdata_i;
                        end else begin
                            // Fetches are always full-word reads
                            grant_r     <= 2'b01;
                            bus_we_r    <= 1'b0;
                            bus_addr_r  <= bus.if_addr_i;
                            bus_sel_r   <= 4'hF;
                            bus_wdata_r <= 32'h0000_0000;
                        end
                    end else begin
                        grant_r <= 2'b00;
                    end
                end
                ST_BUSY: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        // Final bus cycle: memory data is valid now
                        if (grant_r[1]) begin
                            if (!bus_we_r) begin
                                mem_rdata_r <= bus.bus_rdata_i;
                            end
                            mem_ack_r <= 1'b1;
                        end else begin
                            if_data_r <= bus.bus_rdata_i;
                            if_ack_r  <= 1'b1;
                        end
                        bus_ce_r  <= 1'b0;
                        bus_we_r  <= 1'b0;
                        bus_sel_r <= 4'h0;
                        state_r   <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if_ack_r  <= 1'b0;
                    mem_ack_r <= 1'b0;
                    grant_r   <= 2'b00;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    bus_ce_r  <= 1'b0;
                    bus_we_r  <= 1'b0;
                    bus_sel_r <= 4'h0;
                    grant_r   <= 2'b00;
                    if_ack_r  <= 1'b0;
                    mem_ack_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.if_data_o   = if_data_r;
    assign bus.if_ack_o    = if_ack_r;
    assign bus.mem_rdata_o = mem_rdata_r;
    assign bus.mem_ack_o   = mem_ack_r;
    assign bus.grant_o     = grant_r;
    assign bus.bus_ce_o    = bus_ce_r;
    assign bus.bus_we_o    = bus_we_r;
    assign bus.bus_addr_o  = bus_addr_r;
    assign bus.bus_sel_o   = bus_sel_r;
    assign bus.bus_wdata_o = bus_wdata_r;

    // A requester is stalled until the cycle its own acknowledge is seen
    assign bus.stall_req_o = (bus.if_ce_i & ~if_ack_r) | (bus.mem_ce_i & ~mem_ack_r);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (one and zero wait states) checked
// every cycle against a transaction-level model, plus directed scenarios
// with hand-computed expectations.
module tb_mem_arbiter;

    logic clk;
    logic rst;

    mem_arbiter_if i1 ();
    mem_arbiter_if i0 ();

    mem_arbiter #(.WAIT_STATES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(i1.slave));
    mem_arbiter #(.WAIT_STATES(0)) u_dut0 (.clk(clk), .rst(rst), .bus(i0.slave));

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: ph counts cycles since the grant (0 = no access in flight).
    // Bus is driven for ph = 1..ws+1, ack shows at ph = ws+2.
    typedef struct {
        int          ph;
        bit          owner;   // 1 = MEM
        bit          last;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        bit          we;
        logic [31:0] if_data;
        logic [31:0] mem_rdata;
    } mdl_t;

    mdl_t m1;
    mdl_t m0;

    function automatic mdl_t step(input mdl_t s, input int ws, input logic r,
                                  input logic ifce, input logic [31:0] ifaddr,
                                  input logic mce, input logic mwe, input logic [31:0] maddr,
                                  input logic [3:0] msel, input logic [31:0] mwd,
                                  input logic [31:0] rd);
        mdl_t n;
        bit   w;
        n = s;
        if (r) begin
            n.ph = 0; n.owner = 1'b0; n.last = 1'b0; n.addr = 32'h0; n.wdata = 32'h0;
            n.sel = 4'h0; n.we = 1'b0; n.if_data = 32'h0; n.mem_rdata = 32'h0;
        end else if (s.ph == 0) begin
            if (ifce || mce) begin
                w = (ifce && mce) ? !s.last : bit'(mce);
                n.owner = w;
                n.last  = w;
                n.ph    = 1;
                if (w) begin
                    n.addr = maddr; n.sel = msel; n.we = mwe; n.wdata = mwd;
                end else begin
                    n.addr = ifaddr; n.sel = 4'hF; n.we = 1'b0; n.wdata = 32'h0;
                end
            end
        end else if (s.ph == ws + 1) begin
            if (!s.we) begin
                if (s.owner) n.mem_rdata = rd;
                else         n.if_data   = rd;
            end
            n.ph = ws + 2;
        end else if (s.ph == ws + 2) begin
            n.ph = 0;
        end else begin
            n.ph = s.ph + 1;
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_dut(input string tag, input mdl_t s, input int ws,
                           input logic ifce, input logic mce,
                           input logic [1:0] grant, input logic bce, input logic bwe,
                           input logic [31:0] baddr, input logic [3:0] bsel,
                           input logic [31:0] bwd, input logic ifack, input logic mack,
                           input logic [31:0] ifd, input logic [31:0] mrd, input logic stall);
        bit         act;
        bit         ackc;
        logic       e_ifack;
        logic       e_mack;
        logic [1:0] e_grant;
        act     = (s.ph >= 1) && (s.ph <= ws + 1);
        ackc    = (s.ph == ws + 2);
        e_ifack = ackc && !s.owner;
        e_mack  = ackc && s.owner;
        e_grant = (s.ph == 0) ? 2'b00 : (s.owner ? 2'b10 : 2'b01);
        chk({tag, ".grant"},   {30'h0, grant}, {30'h0, e_grant});
        chk({tag, ".bus_ce"},  {31'h0, bce},   {31'h0, act});
        chk({tag, ".bus_we"},  {31'h0, bwe},   {31'h0, (act && s.we)});
        chk({tag, ".bus_addr"}, baddr, s.addr);
        chk({tag, ".bus_sel"}, {28'h0, bsel},  {28'h0, (act ? s.sel : 4'h0)});
        chk({tag, ".bus_wdata"}, bwd, s.wdata);
        chk({tag, ".if_ack"},  {31'h0, ifack}, {31'h0, e_ifack});
        chk({tag, ".mem_ack"}, {31'h0, mack},  {31'h0, e_mack});
        chk({tag, ".if_data"}, ifd, s.if_data);
        chk({tag, ".mem_rdata"}, mrd, s.mem_rdata);
        chk({tag, ".stall"},   {31'h0, stall},
            {31'h0, ((ifce & ~e_ifack) | (mce & ~e_mack))});
    endtask

    // Model advance on each rising edge, using the inputs the DUT samples
    initial begin
        forever begin
            @(posedge clk);
            m1 = step(m1, 1, rst, i1.if_ce_i, i1.if_addr_i, i1.mem_ce_i, i1.mem_we_i,
                      i1.mem_addr_i, i1.mem_sel_i, i1.mem_wdata_i, i1.bus_rdata_i);
            m0 = step(m0, 0, rst, i0.if_ce_i, i0.if_addr_i, i0.mem_ce_i, i0.mem_we_i,
                      i0.mem_addr_i, i0.mem_sel_i, i0.mem_wdata_i, i0.bus_rdata_i);
        end
    end

    // Compare both instances against the model on every falling edge
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk_dut("d1", m1, 1, i1.if_ce_i, i1.mem_ce_i, i1.grant_o, i1.bus_ce_o, i1.bus_we_o,
                    i1.bus_addr_o, i1.bus_sel_o, i1.bus_wdata_o, i1.if_ack_o, i1.mem_ack_o,
                    i1.if_data_o, i1.mem_rdata_o, i1.stall_req_o);
            chk_dut("d0", m0, 0, i0.if_ce_i, i0.mem_ce_i, i0.grant_o, i0.bus_ce_o, i0.bus_we_o,
                    i0.bus_addr_o, i0.bus_sel_o, i0.bus_wdata_o, i0.if_ack_o, i0.mem_ack_o,
                    i0.if_data_o, i0.mem_rdata_o, i0.stall_req_o);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] exp_grant [4];
    int         g;

    initial begin
        exp_grant[0] = 2'b10; exp_grant[1] = 2'b01; exp_grant[2] = 2'b10; exp_grant[3] = 2'b01;
        rst = 1'b1;
        i1.if_ce_i = 1'b0; i1.if_addr_i = 32'h0; i1.mem_ce_i = 1'b0; i1.mem_we_i = 1'b0;
        i1.mem_addr_i = 32'h0; i1.mem_sel_i = 4'h0; i1.mem_wdata_i = 32'h0; i1.bus_rdata_i = 32'h0;
        i0.if_ce_i = 1'b0; i0.if_addr_i = 32'h0; i0.mem_ce_i = 1'b0; i0.mem_we_i = 1'b0;
        i0.mem_addr_i = 32'h0; i0.mem_sel_i = 4'h0; i0.mem_wdata_i = 32'h0; i0.bus_rdata_i = 32'h0;
        tick();
        tick();
        chk("rst_grant",  {30'h0, i1.grant_o}, 32'h0);
        chk("rst_bus_ce", {31'h0, i1.bus_ce_o}, 32'h0);
        chk("rst_if_data", i1.if_data_o, 32'h0);
        chk("rst_mem_rdata", i1.mem_rdata_o, 32'h0);
        rst = 1'b0;
        tick();

        // Single fetch, one wait state
        i1.if_ce_i = 1'b1; i1.if_addr_i = 32'h0000_0010; i1.bus_rdata_i = 32'h2401_0005;
        tick();
        chk("fetch_ce_t1",  {31'h0, i1.bus_ce_o}, 32'h1);
        chk("fetch_addr",   i1.bus_addr_o, 32'h0000_0010);
        chk("fetch_sel",    {28'h0, i1.bus_sel_o}, 32'hF);
        chk("fetch_stall1", {31'h0, i1.stall_req_o}, 32'h1);
        tick();
        chk("fetch_ce_t2",  {31'h0, i1.bus_ce_o}, 32'h1);
        chk("fetch_noack_t2", {31'h0, i1.if_ack_o}, 32'h0);
        chk("fetch_stall2", {31'h0, i1.stall_req_o}, 32'h1);
        tick();
        chk("fetch_ack_t3", {31'h0, i1.if_ack_o}, 32'h1);
        chk("fetch_data",   i1.if_data_o, 32'h2401_0005);
        chk("fetch_stall3", {31'h0, i1.stall_req_o}, 32'h0);
        chk("fetch_ce_t3",  {31'h0, i1.bus_ce_o}, 32'h0);
        i1.if_ce_i = 1'b0;
        tick();
        chk("fetch_ack_t4", {31'h0, i1.if_ack_o}, 32'h0);

        // Data write, with the address changed while the access is in flight
        i1.mem_ce_i = 1'b1; i1.mem_we_i = 1'b1; i1.mem_addr_i = 32'h0000_0100;
        i1.mem_sel_i = 4'b0011; i1.mem_wdata_i = 32'hDEAD_BEEF; i1.bus_rdata_i = 32'hA5A5_A5A5;
        tick();
        chk("wr_we",    {31'h0, i1.bus_we_o}, 32'h1);
        chk("wr_addr1", i1.bus_addr_o, 32'h0000_0100);
        chk("wr_sel",   {28'h0, i1.bus_sel_o}, 32'h3);
        chk("wr_wdata", i1.bus_wdata_o, 32'hDEAD_BEEF);
        chk("wr_grant", {30'h0, i1.grant_o}, 32'h2);
        i1.mem_addr_i = 32'h0000_0300;
        tick();
        chk("wr_addr2", i1.bus_addr_o, 32'h0000_0100);
        tick();
        chk("wr_ack",   {31'h0, i1.mem_ack_o}, 32'h1);
        chk("wr_rdata_kept", i1.mem_rdata_o, 32'h0);
        chk("wr_addr3", i1.bus_addr_o, 32'h0000_0100);
        i1.mem_ce_i = 1'b0; i1.mem_we_i = 1'b0;
        tick();
        chk("wr_ack_once", {31'h0, i1.mem_ack_o}, 32'h0);

        // Zero wait-state read on the second instance
        i0.mem_ce_i = 1'b1; i0.mem_we_i = 1'b0; i0.mem_addr_i = 32'h0000_0200;
        i0.mem_sel_i = 4'hF; i0.bus_rdata_i = 32'h1234_5678;
        tick();
        chk("ws0_ce",    {31'h0, i0.bus_ce_o}, 32'h1);
        chk("ws0_addr",  i0.bus_addr_o, 32'h0000_0200);
        chk("ws0_noack", {31'h0, i0.mem_ack_o}, 32'h0);
        tick();
        chk("ws0_ack",   {31'h0, i0.mem_ack_o}, 32'h1);
        chk("ws0_rdata", i0.mem_rdata_o, 32'h1234_5678);
        i0.mem_ce_i = 1'b0;
        tick();

        // Simultaneous requests from reset alternate MEM, IF, MEM, IF
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i1.if_ce_i = 1'b1; i1.if_addr_i = 32'h0000_0400;
        i1.mem_ce_i = 1'b1; i1.mem_we_i = 1'b0; i1.mem_addr_i = 32'h0000_0800; i1.mem_sel_i = 4'hF;
        for (int k = 0; k < 4; k++) begin
            g = 0;
            while (i1.grant_o == 2'b00 && g < 20) begin
                tick();
                g++;
            end
            chk("arb_grant_wait", {31'h0, (g < 20)}, 32'h1);
            chk("arb_grant", {30'h0, i1.grant_o}, {30'h0, exp_grant[k]});
            g = 0;
            while (!(i1.if_ack_o || i1.mem_ack_o) && g < 20) begin
                tick();
                g++;
            end
            chk("arb_ack_wait", {31'h0, (g < 20)}, 32'h1);
            chk("arb_mem_ack", {31'h0, i1.mem_ack_o}, {31'h0, exp_grant[k][1]});
            chk("arb_if_ack",  {31'h0, i1.if_ack_o},  {31'h0, exp_grant[k][0]});
            tick();
        end
        i1.if_ce_i = 1'b0; i1.mem_ce_i = 1'b0;
        tick();
        chk("arb_idle", {30'h0, i1.grant_o}, 32'h0);

        // Reset during the busy phase of a fetch abandons it
        i1.if_ce_i = 1'b1; i1.if_addr_i = 32'h0000_0040; i1.bus_rdata_i = 32'h0BAD_F00D;
        tick();
        chk("rb_grant", {30'h0, i1.grant_o}, 32'h1);
        rst = 1'b1;
        tick();
        chk("rb_ce",    {31'h0, i1.bus_ce_o}, 32'h0);
        chk("rb_grant0", {30'h0, i1.grant_o}, 32'h0);
        chk("rb_noack", {31'h0, i1.if_ack_o}, 32'h0);
        rst = 1'b0;
        g = 0;
        while (!i1.if_ack_o && g < 20) begin
            tick();
            g++;
        end
        chk("rb_refetch_wait", {31'h0, (g < 20)}, 32'h1);
        chk("rb_refetch_data", i1.if_data_o, 32'h0BAD_F00D);
        i1.if_ce_i = 1'b0;
        tick();

        // Random traffic on both instances, checked by the model
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            i1.if_ce_i     = ($urandom_range(0, 2) != 0);
            i1.if_addr_i   = $urandom;
            i1.mem_ce_i    = ($urandom_range(0, 2) != 0);
            i1.mem_we_i    = ($urandom_range(0, 1) != 0);
            i1.mem_addr_i  = $urandom;
            i1.mem_sel_i   = 4'($urandom);
            i1.mem_wdata_i = $urandom;
            i1.bus_rdata_i = $urandom;
            i0.if_ce_i     = ($urandom_range(0, 2) != 0);
            i0.if_addr_i   = $urandom;
            i0.mem_ce_i    = ($urandom_range(0, 2) != 0);
            i0.mem_we_i    = ($urandom_range(0, 1) != 0);
            i0.mem_addr_i  = $urandom;
            i0.mem_sel_i   = 4'($urandom);
            i0.mem_wdata_i = $urandom;
            i0.bus_rdata_i = $urandom;
            tick();
        end
        rst = 1'b0;
        i1.if_ce_i = 1'b0; i1.mem_ce_i = 1'b0;
        i0.if_ce_i = 1'b0; i0.mem_ce_i = 1'b0;
        repeat (6) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares one single-ported unified memory bus between the instruction-fetch port (PC/IF) and the data port (MEM stage). It serialises accesses through a small FSM that inserts a parameterised number of memory wait states. It returns read data and a one-cycle acknowledge to each requester, and drives a stall request to the pipeline controller while any request is outstanding. It sits between the CPU's rom_*/ram_* ports and the external memory.

## Interface
- WAIT_STATES, 1, extra bus cycles per access (legal 0..15); each access holds the bus for WAIT_STATES+1 cycles.
- clk  in  1  system clock, all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- if_ce_i  in  1  fetch request (level)
- if_addr_i  in  32  fetch address
- if_data_o  out  32  fetched word; valid from the if_ack_o cycle until the next fetch ack
- if_ack_o  out  1  one-cycle fetch completion pulse
- mem_ce_i  in  1  data request (level)
- mem_we_i  in  1  1 = write, 0 = read
- mem_addr_i  in  32  data address
- mem_sel_i  in  4  byte enables
- mem_wdata_i  in  32  write data
- mem_rdata_o  out  32  read word; valid from the mem_ack_o cycle of a read until the next read ack
- mem_ack_o  out  1  one-cycle data completion pulse (reads and writes)
- stall_req_o  out  1  pipeline stall request
- grant_o  out  2  current bus owner: [0] = IF, [1] = MEM; 2'b00 when idle
- bus_ce_o  out  1  memory chip enable
- bus_we_o  out  1  memory write enable
- bus_addr_o  out  32  memory address
- bus_sel_o  out  4  memory byte enables
- bus_wdata_o  out  32  memory write data
- bus_rdata_i  in  32  memory read data, valid on the final cycle of an access

## Operation
- FSM states:
  - IDLE: no owner. Arbitrates each cycle.
  - BUSY: access in flight. Counter cnt, 4 bits.
  - ACK: completion cycle.
- IDLE arbitration:
  - If exactly one of if_ce_i / mem_ce_i is high, that port wins.
  - If both are high, the port that did not win the previous arbitration wins (register last_grant).
  - last_grant resets to IF, so MEM wins the first conflict.
  - On a grant:
    - Latch the winner's address, sel, we and wdata into the bus_* registers. IF always uses sel = 4'hF, we = 0, wdata = 0.
    - Set bus_ce_o = 1, cnt = WAIT_STATES, grant_o = winner, last_grant = winner.
    - Next state is BUSY.
- BUSY:
  - bus_* outputs are held constant.
  - If cnt != 0, decrement cnt.
  - If cnt == 0, sample bus_rdata_i into the winner's data register (read only; writes leave mem_rdata_o unchanged). Then clear bus_ce_o, bus_we_o and bus_sel_o, pulse the winner's ack, and go to ACK.
- ACK:
  - The winner's ack is high for exactly this cycle; grant_o keeps the winner.
  - Next state is IDLE unconditionally, with grant_o cleared.
- Requester rules:
  - Inputs are latched at grant. Later changes, including dropping ce, do not affect the in-flight access.
  - A ce still high in the cycle after ack is a new request.
- stall_req_o is combinational: (if_ce_i & ~if_ack_o) | (mem_ce_i & ~mem_ack_o).
- Address and data pass through unmodified. No alignment check.

## Timing
- Request high in IDLE cycle T:
  - BUSY occupies cycles T+1 .. T+1+WAIT_STATES.
  - Ack and data appear in cycle T+2+WAIT_STATES.
  - The next arbitration happens in IDLE at T+3+WAIT_STATES.
- Throughput: one access per WAIT_STATES+3 cycles. With WAIT_STATES=0 an access takes 3 cycles.
- Reset values: all outputs 0; state IDLE; cnt 0; last_grant IF; data registers 0.
- Reset in any state:
  - Next cycle is IDLE with bus_ce_o = 0.
  - The in-flight access is abandoned and no ack is issued.
- A request arriving while BUSY or in ACK waits. stall_req_o stays high until that request's ack.
- Both requests remain asserted continuously: grants alternate MEM, IF, MEM, IF, …

## Test plan
- Single fetch, WAIT_STATES=1:
  - Stimulus: if_ce_i=1, if_addr_i=0x0000_0010 at T; memory returns 0x2401_0005.
  - Required: bus_ce_o high for T+1..T+2 with bus_addr_o=0x10 and bus_sel_o=4'hF; if_ack_o pulses at T+3 with if_data_o=0x2401_0005; stall_req_o is low only at T+3.
- Data write:
  - Stimulus: mem_ce_i=1, mem_we_i=1, mem_addr_i=0x100, mem_sel_i=4'b0011, mem_wdata_i=0xDEAD_BEEF.
  - Required: the bus shows these values with bus_we_o=1; mem_ack_o pulses once; mem_rdata_o is unchanged.
- Simultaneous requests held for 4 grants, from reset:
  - Required: grant_o sequence is 2'b10, 2'b01, 2'b10, 2'b01; acks alternate mem, if, mem, if.
- WAIT_STATES=0 read at address 0x200 returning 0x1234_5678:
  - Required: ack 2 cycles after the request cycle; mem_rdata_o=0x1234_5678.
- Reset asserted during BUSY of a fetch:
  - Required: next cycle has bus_ce_o=0, grant_o=0, no if_ack_o; a fetch re-requested after reset completes normally.
- mem_addr_i changed from 0x100 to 0x300 mid-BUSY:
  - Required: bus_addr_o stays 0x100 for the whole access.
